serv_alu_ds: RTL and testbench
==============================

// Module: serv_alu_ds
// PURPOSE
//  Digit-serial ALU: successor of the bit-serial ALU, handling W bits/cycle over NDIG=XLEN/W digits, LSB digit first.
//  Pass 1 (i_init): compare, load shifter, latch shamt. Pass 2 (i_en): emit result on o_rd.
//  Adds a multi-cycle shift engine with a done flag. Sits between the register-file serialiser and the rd write port.
// PARAMETERS
//  W     4   digit width; legal values 1,2,4,8
//  XLEN  32  operand width; NDIG=XLEN/W is a localparam
// PORTS
//  clk          in   1  clock, rising edge
//  i_rst_n      in   1  synchronous active-low reset
//  i_init       in   1  operand pass; high for exactly NDIG cycles
//  i_en         in   1  result pass; high for exactly NDIG cycles
//  i_cnt_done   in   1  marks the last digit of the current pass
//  i_rs1        in   W  rs1 digit
//  i_op_b       in   W  rs2/imm digit
//  i_sub        in   1  add: 0 = a+b, 1 = a-b
//  i_bool_op    in   2  00 xor, 01 eq(xnor), 10 or, 11 and
//  i_cmp_sel    in   1  ALU_CMP_EQ / ALU_CMP_LT
//  i_cmp_neg    in   1  invert o_cmp
//  i_cmp_uns    in   1  unsigned less-than
//  i_sh_right   in   1  shift direction
//  i_sh_signed  in   1  arithmetic right shift
//  i_rd_sel     in   2  ALU_RESULT_ADD/SR/LT/BOOL
//  o_cmp        out  1  compare result; valid from cycle after last init digit until next i_init
//  o_sh_done    out  1  shift engine in DONE
//  o_rd         out  W  result digit
// BEHAVIOUR
//  Reset: carry=0, eq_r=0, lt_r=0, state=IDLE, shamt=0, buf=0, o_sh_done=0, o_cmp=i_cmp_neg.
//  first = pass strobe high while it was low the previous cycle (en_r/init_r registers).
//  Adder: {c,s} = a + (b ^ {W{i_sub}}) + cin, where cin = first ? i_sub : carry_r.
//   - carry_r updated every i_en cycle; o_rd=s is combinational, same cycle (zero latency).
//  Eq: eq_r <= (first ? 1 : eq_r) & (a==b), updated each init cycle.
//  Lt: per digit, lt_r <= (a<b) | ((a==b) & (first ? 0 : lt_r)).
//   - On the i_cnt_done digit the MSB compares signed unless i_cmp_uns.
//  o_cmp = i_cmp_neg ^ (sel==EQ ? eq_r : lt_r); held stable outside i_init.
//  SLT: first result digit = {0..,lt_r}; later digits = 0.
//  Bool: per-bit LUT 16'h8E96 indexed {bool_op,a_i,b_i}. Undefined i_rd_sel -> o_rd=0.
//  Shift FSM: IDLE -> LOAD -> SHIFT -> DONE.
//   - IDLE -> LOAD on first i_init cycle.
//   - LOAD: buf <= {rs1, buf[XLEN-1:W]}; shamt[4:0] collected from the low 5 bits of op_b
//     (first ceil(5/W) digits, W>=5 uses digit 0 only).
//   - At end of LOAD (i_cnt_done): to SHIFT if shamt!=0, else to DONE.
//   - SHIFT: one bit per cycle; right shift fills buf[XLEN-1] if signed, else 0; left fills 0.
//     shamt decrements each cycle; to DONE when shamt==1. Latency = shamt cycles.
//   - DONE: o_sh_done=1. During i_en with SR selected, o_rd = buf[W-1:0] and buf >>= W.
//     DONE -> IDLE on the i_en i_cnt_done cycle.
//   - The FSM runs for every instruction; o_sh_done is ignored by the caller unless rd_sel=SR.
//  i_init while in SHIFT/DONE: abort and restart LOAD with the new operands (no stale data).
//  i_init and i_en both high: illegal; i_init wins for the FSM, adder still uses i_en.
//  Reset mid-pass: everything returns to reset values next edge; the partial pass is discarded.
// STRUCTURE
//  Constants ALU_RESULT_*, ALU_CMP_*, BOOL_LUT stay in the shared serv_params.vh.
//  New localparams: FSM state encodings, NDIG, SHCNT_W=5.
//  One sub-module: ser_add_w (W-bit digit adder with carry register, clr, first-digit cin select).
//  Used once for the main add; 2's-complement negation folds into cin, so no second adder is needed.
// TESTING (W=4 and W=1 both run)
//  add 0x7FFFFFFF+1, i_sub=0 -> o_rd digits give 0x80000000; sub 5-7 -> 0xFFFFFFFE.
//  slt -1 vs 1: signed -> first digit LSB=1 (result 1); i_cmp_uns=1 -> 0; eq 0x1234 vs 0x1234 -> o_cmp=1, with neg -> 0.
//  sra 0x80000000 by 31 -> o_sh_done after 31 cycles, result 0xFFFFFFFF; srl -> 0x00000001.
//  sll 0x00000001 by 0 -> DONE directly after LOAD, result 0x00000001.
//  bool 0xF0F0F0F0 and/or/xor 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
//  i_rst_n low mid-SHIFT -> next cycle state IDLE, o_sh_done=0; i_init during SHIFT -> reload and correct new result.

Source files
------------

// File: rtl/serv_alu_ds_pkg.sv
// Shared constants and types for the digit-serial ALU.
// Result/compare selects, boolean LUT and shift FSM states.
package serv_alu_ds_pkg;

  localparam logic [1:0] ALU_RESULT_ADD  = 2'd0;
  localparam logic [1:0] ALU_RESULT_SR   = 2'd1;
  localparam logic [1:0] ALU_RESULT_LT   = 2'd2;
  localparam logic [1:0] ALU_RESULT_BOOL = 2'd3;

  localparam logic ALU_CMP_EQ = 1'b0;
  localparam logic ALU_CMP_LT = 1'b1;

  localparam logic [15:0] BOOL_LUT = 16'h8E96;
  localparam int          SHCNT_W  = 5;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_LOAD,
    SH_SHIFT,
    SH_DONE
  } sh_state_t;

  function automatic logic bool_bit(
    input logic [1:0] op,
    input logic       a,
    input logic       b
  );
    return BOOL_LUT[{op, a, b}];
  endfunction

endpackage

// File: rtl/serv_alu_ds_ser_add_w.sv
// W-bit digit adder with registered carry.
// Subtraction folds the two's-complement +1 into the first-digit carry-in.
module ser_add_w #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_first,
  input  logic         i_sub,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_s
);

  logic         carry_r;
  logic         cin;
  logic [W:0]   sum;

  assign cin = i_first ? i_sub : carry_r;
  assign sum = {1'b0, i_a}
             + {1'b0, i_b ^ {W{i_sub}}}
             + {{W{1'b0}}, cin};
  assign o_s = sum[W-1:0];

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr)
      carry_r <= 1'b0;
    else if (i_en)
      carry_r <= sum[W];
  end

endmodule

// File: rtl/serv_alu_ds.sv
// Digit-serial ALU: add/sub, compare, bool and a multi-cycle
// shift engine, W bits per cycle, LSB digit first.
module serv_alu_ds
  import serv_alu_ds_pkg::*;
#(
  parameter int W    = 4,
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_init,
  input  logic         i_en,
  input  logic         i_cnt_done,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_op_b,
  input  logic         i_sub,
  input  logic [1:0]   i_bool_op,
  input  logic         i_cmp_sel,
  input  logic         i_cmp_neg,
  input  logic         i_cmp_uns,
  input  logic         i_sh_right,
  input  logic         i_sh_signed,
  input  logic [1:0]   i_rd_sel,
  output logic         o_cmp,
  output logic         o_sh_done,
  output logic [W-1:0] o_rd
);

  localparam int NDIG  = XLEN / W;
  localparam int IDX_W = $clog2(NDIG) + 1;

  logic               init_r;
  logic               en_r;
  logic               first_init;
  logic               first_en;
  logic               eq_r;
  logic               lt_r;
  logic               dig_eq;
  logic               dig_lt;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx;
  logic [SHCNT_W-1:0] shamt_r;
  logic [SHCNT_W-1:0] shamt_nxt;
  logic [XLEN-1:0]    sh_buf;
  logic [W-1:0]       add_s;
  logic [W-1:0]       bool_s;
  sh_state_t          state;
  sh_state_t          state_nxt;

  assign first_init = i_init & ~init_r;
  assign first_en   = i_en & ~en_r;

  ser_add_w #(.W(W)) u_add (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_init & ~i_en),
    .i_en    (i_en),
    .i_first (first_en),
    .i_sub   (i_sub),
    .i_a     (i_rs1),
    .i_b     (i_op_b),
    .o_s     (add_s)
  );

  // Only the top digit carries the sign for signed compares.
  assign dig_eq = (i_rs1 == i_op_b);
  assign dig_lt = (i_cnt_done && !i_cmp_uns)
                ? ($signed(i_rs1) < $signed(i_op_b))
                : (i_rs1 < i_op_b);

  assign idx = first_init ? '0 : idx_r;

  always_comb begin
    shamt_nxt = shamt_r;
    if (i_init) begin
      for (int k = 0; k < SHCNT_W; k++)
        if (idx == IDX_W'(k / W))
          shamt_nxt[k] = i_op_b[k % W];
    end else if (state == SH_SHIFT) begin
      shamt_nxt = shamt_r - SHCNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_init) begin
      if (!i_cnt_done)
        state_nxt = SH_LOAD;
      else if (shamt_nxt != '0)
        state_nxt = SH_SHIFT;
      else
        state_nxt = SH_DONE;
    end else begin
      unique case (state)
        SH_SHIFT:
          if (shamt_r == SHCNT_W'(1))
            state_nxt = SH_DONE;
        SH_DONE:
          if (i_en && i_cnt_done)
            state_nxt = SH_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n)
      state <= SH_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      init_r  <= 1'b0;
      en_r    <= 1'b0;
      eq_r    <= 1'b0;
      lt_r    <= 1'b0;
      idx_r   <= '0;
      shamt_r <= '0;
      sh_buf  <= '0;
    end else begin
      init_r  <= i_init;
      en_r    <= i_en;
      shamt_r <= shamt_nxt;
      if (i_init) begin
        idx_r  <= idx + IDX_W'(1);
        eq_r   <= (first_init | eq_r) & dig_eq;
        lt_r   <= dig_lt | (dig_eq & ~first_init & lt_r);
        sh_buf <= {i_rs1, sh_buf[XLEN-1:W]};
      end else if (state == SH_SHIFT) begin
        sh_buf <= i_sh_right
                ? {i_sh_signed & sh_buf[XLEN-1], sh_buf[XLEN-1:1]}
                : {sh_buf[XLEN-2:0], 1'b0};
      end else if (state == SH_DONE && i_en &&
                   i_rd_sel == ALU_RESULT_SR) begin
        sh_buf <= sh_buf >> W;
      end
    end
  end

  always_comb begin
    bool_s = '0;
    for (int i = 0; i < W; i++)
      bool_s[i] = bool_bit(i_bool_op, i_rs1[i], i_op_b[i]);
  end

  always_comb begin
    o_rd = '0;
    unique case (i_rd_sel)
      ALU_RESULT_ADD:  o_rd = add_s;
      ALU_RESULT_SR:   o_rd = sh_buf[W-1:0];
      ALU_RESULT_LT:   o_rd[0] = first_en & lt_r;
      ALU_RESULT_BOOL: o_rd = bool_s;
      default:         o_rd = '0;
    endcase
  end

  assign o_cmp     = i_cmp_neg ^ ((i_cmp_sel == ALU_CMP_EQ) ? eq_r : lt_r);
  assign o_sh_done = (state == SH_DONE);

endmodule

// File: tb/tb_serv_alu_ds.sv
// Testbench for serv_alu_ds: W=4 and W=1 instances, directed table,
// hand-written reset/abort sequences and random ops against a model.
module tb_serv_alu_ds;
  import serv_alu_ds_pkg::*;

  typedef struct {
    logic [1:0]  rd_sel;
    logic        sub;
    logic [1:0]  bop;
    logic        csel;
    logic        cneg;
    logic        cuns;
    logic        shr;
    logic        shs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_rd;
    logic        exp_cmp;
    logic        chk_cmp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cnt_done;
  logic       sub;
  logic [1:0] bool_op;
  logic       cmp_sel;
  logic       cmp_neg;
  logic       cmp_uns;
  logic       sh_right;
  logic       sh_signed;
  logic [1:0] rd_sel;

  logic       init4, en4, cmp4, done4;
  logic [3:0] rs1_4, opb_4, rd4;
  logic       init1, en1, cmp1, done1;
  logic [0:0] rs1_1, opb_1, rd1;

  int n_chk  = 0;
  int n_fail = 0;
  int dw     = 4;

  always #5 clk = ~clk;

  serv_alu_ds #(.W(4), .XLEN(32)) u4 (
    .clk(clk), .i_rst_n(rst_n), .i_init(init4), .i_en(en4),
    .i_cnt_done(cnt_done), .i_rs1(rs1_4), .i_op_b(opb_4),
    .i_sub(sub), .i_bool_op(bool_op), .i_cmp_sel(cmp_sel),
    .i_cmp_neg(cmp_neg), .i_cmp_uns(cmp_uns),
    .i_sh_right(sh_right), .i_sh_signed(sh_signed),
    .i_rd_sel(rd_sel), .o_cmp(cmp4), .o_sh_done(done4), .o_rd(rd4)
  );

  serv_alu_ds #(.W(1), .XLEN(32)) u1 (
    .clk(clk), .i_rst_n(rst_n), .i_init(init1), .i_en(en1),
    .i_cnt_done(cnt_done), .i_rs1(rs1_1), .i_op_b(opb_1),
    .i_sub(sub), .i_bool_op(bool_op), .i_cmp_sel(cmp_sel),
    .i_cmp_neg(cmp_neg), .i_cmp_uns(cmp_uns),
    .i_sh_right(sh_right), .i_sh_signed(sh_signed),
    .i_rd_sel(rd_sel), .o_cmp(cmp1), .o_sh_done(done1), .o_rd(rd1)
  );

  function automatic logic cur_done();
    return (dw == 4) ? done4 : done1;
  endfunction

  function automatic logic cur_cmp();
    return (dw == 4) ? cmp4 : cmp1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (W=%0d): got %h expected %h", nm, dw, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] rs, input logic sb, input logic [1:0] bo,
    input logic cs, input logic cn, input logic cu,
    input logic hr, input logic hs,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] er, input logic ec, input logic cc);
    vec_t v;
    v.rd_sel = rs; v.sub = sb; v.bop = bo;
    v.csel = cs; v.cneg = cn; v.cuns = cu;
    v.shr = hr; v.shs = hs; v.a = a; v.b = b;
    v.exp_rd = er; v.exp_cmp = ec; v.chk_cmp = cc;
    return v;
  endfunction

  // Whole-word reference: plain 32-bit arithmetic on the operands.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic lt;
    logic eq;
    int   sh;
    r  = v;
    sh = int'(v.b[4:0]);
    eq = (v.a == v.b);
    lt = v.cuns ? (v.a < v.b) : ($signed(v.a) < $signed(v.b));
    case (v.rd_sel)
      ALU_RESULT_ADD: r.exp_rd = v.sub ? v.a - v.b : v.a + v.b;
      ALU_RESULT_SR:
        if (!v.shr)     r.exp_rd = v.a << sh;
        else if (v.shs) r.exp_rd = 32'($signed(v.a) >>> sh);
        else            r.exp_rd = v.a >> sh;
      ALU_RESULT_LT:  r.exp_rd = {31'b0, lt};
      default:
        case (v.bop)
          2'd0:    r.exp_rd = v.a ^ v.b;
          2'd1:    r.exp_rd = ~(v.a ^ v.b);
          2'd2:    r.exp_rd = v.a | v.b;
          default: r.exp_rd = v.a & v.b;
        endcase
    endcase
    r.exp_cmp = v.cneg ^ (v.csel ? lt : eq);
    return r;
  endfunction

  task automatic set_dig(input logic ini, input logic en,
                         input logic [31:0] a, input logic [31:0] b,
                         input int i);
    if (dw == 4) begin
      init4 = ini; en4 = en;
      rs1_4 = a[i*4 +: 4]; opb_4 = b[i*4 +: 4];
    end else begin
      init1 = ini; en1 = en;
      rs1_1 = a[i]; opb_1 = b[i];
    end
  endtask

  task automatic pass(input logic ini, input logic [31:0] a,
                      input logic [31:0] b, output logic [31:0] res);
    int nd;
    nd  = 32 / dw;
    res = '0;
    for (int i = 0; i < nd; i++) begin
      set_dig(ini, !ini, a, b, i);
      cnt_done = (i == nd - 1);
      @(negedge clk);
      if (dw == 4) res[i*4 +: 4] = rd4;
      else         res[i] = rd1[0];
      @(posedge clk); #1;
    end
    set_dig(1'b0, 1'b0, a, b, 0);
    cnt_done = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!cur_done() && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic set_mode(input vec_t v);
    rd_sel = v.rd_sel; sub = v.sub; bool_op = v.bop;
    cmp_sel = v.csel; cmp_neg = v.cneg; cmp_uns = v.cuns;
    sh_right = v.shr; sh_signed = v.shs;
  endtask

  task automatic exec(input vec_t v, input string nm);
    logic [31:0] junk;
    logic [31:0] res;
    logic        c;
    int          cyc;
    set_mode(v);
    pass(1'b1, v.a, v.b, junk);
    c = cur_cmp();
    wait_done(cyc);
    pass(1'b0, v.a, v.b, res);
    chk({nm, "_rd"}, res, v.exp_rd);
    if (v.chk_cmp) chk({nm, "_cmp"}, 32'(c), 32'(v.exp_cmp));
    chk({nm, "_lat"}, 32'(cyc), 32'(v.b[4:0]));
    chk({nm, "_idle"}, 32'(cur_done()), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    vec_t        v;
    logic [31:0] junk;
    int          widths[2];

    tbl[0]  = mk(ALU_RESULT_ADD, 0, 0, 0, 0, 0, 0, 0,
                 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0);
    tbl[1]  = mk(ALU_RESULT_ADD, 1, 0, 0, 0, 0, 0, 0,
                 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0);
    tbl[2]  = mk(ALU_RESULT_LT, 0, 0, ALU_CMP_LT, 0, 0, 0, 0,
                 32'hFFFFFFFF, 32'h1, 32'h1, 1, 1);
    tbl[3]  = mk(ALU_RESULT_LT, 0, 0, ALU_CMP_LT, 0, 1, 0, 0,
                 32'hFFFFFFFF, 32'h1, 32'h0, 0, 1);
    tbl[4]  = mk(ALU_RESULT_BOOL, 0, 3, ALU_CMP_EQ, 0, 0, 0, 0,
                 32'h1234, 32'h1234, 32'h1234, 1, 1);
    tbl[5]  = mk(ALU_RESULT_BOOL, 0, 3, ALU_CMP_EQ, 1, 0, 0, 0,
                 32'h1234, 32'h1234, 32'h1234, 0, 1);
    tbl[6]  = mk(ALU_RESULT_SR, 0, 0, 0, 0, 0, 1, 1,
                 32'h80000000, 32'd31, 32'hFFFFFFFF, 0, 0);
    tbl[7]  = mk(ALU_RESULT_SR, 0, 0, 0, 0, 0, 1, 0,
                 32'h80000000, 32'd31, 32'h00000001, 0, 0);
    tbl[8]  = mk(ALU_RESULT_SR, 0, 0, 0, 0, 0, 0, 0,
                 32'h00000001, 32'd0, 32'h00000001, 0, 0);
    tbl[9]  = mk(ALU_RESULT_BOOL, 0, 3, 0, 0, 0, 0, 0,
                 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0);
    tbl[10] = mk(ALU_RESULT_BOOL, 0, 2, 0, 0, 0, 0, 0,
                 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0);
    tbl[11] = mk(ALU_RESULT_BOOL, 0, 0, 0, 0, 0, 0, 0,
                 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0);

    rst_n = 1'b0; cnt_done = 1'b0; sub = 1'b0; bool_op = '0;
    cmp_sel = 1'b0; cmp_neg = 1'b0; cmp_uns = 1'b0;
    sh_right = 1'b0; sh_signed = 1'b0; rd_sel = '0;
    init4 = 1'b0; en4 = 1'b0; rs1_4 = '0; opb_4 = '0;
    init1 = 1'b0; en1 = 1'b0; rs1_1 = '0; opb_1 = '0;
    repeat (3) @(posedge clk);
    #1;

    widths[0] = 4;
    widths[1] = 1;

    cmp_neg = 1'b1; #1;
    for (int w = 0; w < 2; w++) begin
      dw = widths[w];
      chk("rst_cmp_neg1", 32'(cur_cmp()), 32'd1);
      chk("rst_done", 32'(cur_done()), 32'd0);
    end
    cmp_neg = 1'b0; #1;
    for (int w = 0; w < 2; w++) begin
      dw = widths[w];
      chk("rst_cmp_neg0", 32'(cur_cmp()), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 2; w++) begin
      dw = widths[w];

      for (int t = 0; t < 12; t++)
        exec(tbl[t], $sformatf("tbl%0d", t));

      // Reset while the shifter is busy must drop back to idle.
      set_mode(tbl[6]);
      pass(1'b1, tbl[6].a, tbl[6].b, junk);
      repeat (5) @(posedge clk);
      #1;
      chk("mid_shift_busy", 32'(cur_done()), 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_done", 32'(cur_done()), 32'd0);
      chk("mid_rst_cmp", 32'(cur_cmp()), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("mid_rst_idle", 32'(cur_done()), 32'd0);

      // New operands while shifting replace the old ones.
      set_mode(tbl[6]);
      pass(1'b1, tbl[6].a, tbl[6].b, junk);
      repeat (5) @(posedge clk);
      #1;
      v = mk(ALU_RESULT_SR, 0, 0, 0, 0, 0, 1, 0,
             32'h12345678, 32'd4, 32'h01234567, 0, 0);
      exec(v, "abort");

      for (int r = 0; r < 25; r++) begin
        v.rd_sel = 2'($urandom_range(0, 3));
        v.sub    = 1'($urandom_range(0, 1));
        v.bop    = 2'($urandom_range(0, 3));
        v.csel   = 1'($urandom_range(0, 1));
        v.cneg   = 1'($urandom_range(0, 1));
        v.cuns   = 1'($urandom_range(0, 1));
        v.shr    = 1'($urandom_range(0, 1));
        v.shs    = 1'($urandom_range(0, 1));
        v.a      = $urandom;
        v.b      = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
        v.chk_cmp = 1'b1;
        v = model(v);
        exec(v, $sformatf("rand%0d", r));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
